// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a control word,
// held in a 1- or 2-entry elastic buffer with valid/ready handshakes toward execute.
module decode_stage #(
    parameter int PC_W     = 32,
    parameter int DEPTH    = 2,
    parameter int ILLCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr_in,
    input  logic [PC_W-1:0]     pc_in,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                RegWrite,
    output logic                ALUSrc,
    output logic                ALUSrcA,
    output logic [3:0]          ALUCtrl,
    output logic [2:0]          IMMSrc,
    output logic [2:0]          MemCtrl,
    output logic                MemWrite,
    output logic [1:0]          ResultSrc,
    output logic [2:0]          BrCtrl,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [PC_W-1:0]     pc_out,
    output logic                illegal,
    output logic [ILLCNT_W-1:0] ill_count
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_LSL = 4'd5, ALU_LSR = 4'd6, ALU_ASR = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;

    typedef struct packed {
        logic            reg_write;
        logic            alu_src;
        logic            alu_src_a;
        logic [3:0]      alu_ctrl;
        logic [2:0]      imm_src;
        logic [2:0]      mem_ctrl;
        logic            mem_write;
        logic [1:0]      result_src;
        logic [2:0]      br_ctrl;
        logic            illegal;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [PC_W-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t                r_state, w_next_state;
    logic                  r_in_ready;
    entry_t                r_slot0, r_slot1;
    entry_t                w_dec, w_head;
    logic [ILLCNT_W-1:0]   r_ill_count;
    logic                  w_accept, w_push, w_pop, w_load0, w_load1, w_ill;
    logic [6:0]            w_op, w_f7;
    logic [2:0]            w_f3;

    // Shared R/I-ALU mapping; alt selects SUB/ASR where funct7 bit 5 applies.
    function automatic logic [3:0] alu_of_f3(input logic [2:0] f3, input logic alt_add, input logic alt_sr);
        case (f3)
            3'b000:  alu_of_f3 = alt_add ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of_f3 = ALU_LSL;
            3'b010:  alu_of_f3 = ALU_SLT;
            3'b011:  alu_of_f3 = ALU_SLTU;
            3'b100:  alu_of_f3 = ALU_XOR;
            3'b101:  alu_of_f3 = alt_sr ? ALU_ASR : ALU_LSR;
            3'b110:  alu_of_f3 = ALU_OR;
            default: alu_of_f3 = ALU_AND;
        endcase
    endfunction

    assign w_op = instr_in[6:0];
    assign w_f3 = instr_in[14:12];
    assign w_f7 = instr_in[31:25];

    // NOTE: every field gets a default before the case so no path leaves a latch.
    always_comb begin
        w_dec     = '0;
        w_ill     = 1'b0;
        w_dec.rs1 = instr_in[19:15];
        w_dec.rs2 = instr_in[24:20];
        w_dec.rd  = instr_in[11:7];
        w_dec.pc  = pc_in;
        case (w_op)
            OP_R: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_ctrl  = alu_of_f3(w_f3, w_f7[5], w_f7[5]);
                w_ill = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
            end
            OP_I: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = alu_of_f3(w_f3, 1'b0, w_f7[5]);
                w_ill = (w_f3 == 3'b001 && w_f7 != 7'h00) ||
                        (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20);
            end
            OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.mem_ctrl   = w_f3;
                w_dec.result_src = 2'd1;
                w_ill = (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111);
            end
            OP_STORE: begin
                w_dec.alu_src   = 1'b1;
                w_dec.imm_src   = 3'd1;
                w_dec.mem_ctrl  = w_f3;
                w_dec.mem_write = 1'b1;
                w_ill = (w_f3 > 3'b010);
            end
            OP_BR: begin
                w_dec.imm_src = 3'd2;
                case (w_f3)
                    3'b000:  begin w_dec.alu_ctrl = ALU_SUB;  w_dec.br_ctrl = 3'd1; end
                    3'b001:  begin w_dec.alu_ctrl = ALU_SUB;  w_dec.br_ctrl = 3'd2; end
                    3'b100:  begin w_dec.alu_ctrl = ALU_SLT;  w_dec.br_ctrl = 3'd2; end
                    3'b101:  begin w_dec.alu_ctrl = ALU_SLT;  w_dec.br_ctrl = 3'd1; end
                    3'b110:  begin w_dec.alu_ctrl = ALU_SLTU; w_dec.br_ctrl = 3'd2; end
                    3'b111:  begin w_dec.alu_ctrl = ALU_SLTU; w_dec.br_ctrl = 3'd1; end
                    default: w_ill = 1'b1;
                endcase
            end
            OP_JAL: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.alu_src_a  = 1'b1;
                w_dec.imm_src    = 3'd4;
                w_dec.result_src = 2'd2;
                w_dec.br_ctrl    = 3'd3;
            end
            OP_JALR: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'd2;
                w_dec.br_ctrl    = 3'd4;
                w_ill = (w_f3 != 3'b000);
            end
            OP_LUI: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = ALU_PASSB;
                w_dec.imm_src   = 3'd3;
            end
            OP_AUIPC: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_src_a = 1'b1;
                w_dec.imm_src   = 3'd3;
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_dec.reg_write  = 1'b0;
            w_dec.alu_src    = 1'b0;
            w_dec.alu_src_a  = 1'b0;
            w_dec.alu_ctrl   = '0;
            w_dec.imm_src    = '0;
            w_dec.mem_ctrl   = '0;
            w_dec.mem_write  = 1'b0;
            w_dec.result_src = '0;
            w_dec.br_ctrl    = '0;
            w_dec.illegal    = 1'b1;
        end else if (w_dec.rd == 5'd0) begin
            w_dec.reg_write  = 1'b0;
        end
    end

    // Occupancy next-state and handshake outputs; flush overrides every transition.
    always_comb begin
        w_next_state = r_state;
        out_valid    = (r_state != S_EMPTY);
        in_ready     = (DEPTH == 1) ? (r_in_ready && (r_state == S_EMPTY || out_ready)) : r_in_ready;
        w_accept     = in_valid && in_ready;
        w_push       = w_accept && !flush;
        w_pop        = out_valid && out_ready;
        case (r_state)
            S_EMPTY: if (w_push) w_next_state = S_ONE;
            S_ONE: begin
                if (w_push && !w_pop)      w_next_state = S_TWO;
                else if (!w_push && w_pop) w_next_state = S_EMPTY;
            end
            S_TWO:   if (w_pop) w_next_state = S_ONE;
            default: w_next_state = S_EMPTY;
        endcase
        if (flush) w_next_state = S_EMPTY;
    end

    assign w_load0 = (r_state == S_EMPTY && w_push) || (r_state == S_ONE && w_push && w_pop) ||
                     (r_state == S_TWO && w_pop);
    assign w_load1 = (r_state == S_ONE && w_push && !w_pop);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (DEPTH == 1) ? 1'b1 : (w_next_state != S_TWO);
        end
    end

    // NOTE: the two buffer slots are reset too, so pc_out and controls read zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_ill_count <= '0;
        end else begin
            if (w_load0) r_slot0 <= (r_state == S_TWO) ? r_slot1 : w_dec;
            if (w_load1) r_slot1 <= w_dec;
            if (w_push && w_dec.illegal && !(&r_ill_count))
                r_ill_count <= r_ill_count + ILLCNT_W'(1);
        end
    end

    assign w_head    = out_valid ? r_slot0 : '0;
    assign RegWrite  = w_head.reg_write;
    assign ALUSrc    = w_head.alu_src;
    assign ALUSrcA   = w_head.alu_src_a;
    assign ALUCtrl   = w_head.alu_ctrl;
    assign IMMSrc    = w_head.imm_src;
    assign MemCtrl   = w_head.mem_ctrl;
    assign MemWrite  = w_head.mem_write;
    assign ResultSrc = w_head.result_src;
    assign BrCtrl    = w_head.br_ctrl;
    assign rs1       = w_head.rs1;
    assign rs2       = w_head.rs2;
    assign rd        = w_head.rd;
    assign pc_out    = w_head.pc;
    assign illegal   = w_head.illegal;
    assign ill_count = r_ill_count;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, skid stall/drain, illegal counting,
// flush and asynchronous reset; a second instance with a 2-bit counter checks saturation.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush;
    logic [31:0] instr_in, pc_in;

    logic        in_ready, out_valid, RegWrite, ALUSrc, ALUSrcA, MemWrite, illegal;
    logic [3:0]  ALUCtrl;
    logic [2:0]  IMMSrc, MemCtrl, BrCtrl;
    logic [1:0]  ResultSrc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc_out;
    logic [15:0] ill_count;

    logic        s_in_ready, s_out_valid, s_RegWrite, s_ALUSrc, s_ALUSrcA, s_MemWrite, s_illegal;
    logic [3:0]  s_ALUCtrl;
    logic [2:0]  s_IMMSrc, s_MemCtrl, s_BrCtrl;
    logic [1:0]  s_ResultSrc;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [31:0] s_pc_out;
    logic [1:0]  s_ill_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
        .pc_in(pc_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUSrcA(ALUSrcA), .ALUCtrl(ALUCtrl),
        .IMMSrc(IMMSrc), .MemCtrl(MemCtrl), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
        .BrCtrl(BrCtrl), .rs1(rs1), .rs2(rs2), .rd(rd), .pc_out(pc_out),
        .illegal(illegal), .ill_count(ill_count)
    );

    decode_stage #(.ILLCNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .instr_in(instr_in),
        .pc_in(pc_in), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .RegWrite(s_RegWrite), .ALUSrc(s_ALUSrc), .ALUSrcA(s_ALUSrcA), .ALUCtrl(s_ALUCtrl),
        .IMMSrc(s_IMMSrc), .MemCtrl(s_MemCtrl), .MemWrite(s_MemWrite), .ResultSrc(s_ResultSrc),
        .BrCtrl(s_BrCtrl), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .pc_out(s_pc_out),
        .illegal(s_illegal), .ill_count(s_ill_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with execute ready, then check the decoded head a cycle later.
    task automatic send(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic e_rw, input logic e_as, input logic e_aa, input logic [3:0] e_alu,
                        input logic [2:0] e_imm, input logic [2:0] e_mc, input logic e_mw,
                        input logic [1:0] e_res, input logic [2:0] e_br, input logic e_ill,
                        input logic [4:0] e_rd);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr_in  = instr;
        pc_in     = pc;
        step();
        check({tag, ".out_valid"}, out_valid, 1);
        check({tag, ".pc_out"},    pc_out,    pc);
        check({tag, ".RegWrite"},  RegWrite,  e_rw);
        check({tag, ".ALUSrc"},    ALUSrc,    e_as);
        check({tag, ".ALUSrcA"},   ALUSrcA,   e_aa);
        check({tag, ".ALUCtrl"},   ALUCtrl,   e_alu);
        check({tag, ".IMMSrc"},    IMMSrc,    e_imm);
        check({tag, ".MemCtrl"},   MemCtrl,   e_mc);
        check({tag, ".MemWrite"},  MemWrite,  e_mw);
        check({tag, ".ResultSrc"}, ResultSrc, e_res);
        check({tag, ".BrCtrl"},    BrCtrl,    e_br);
        check({tag, ".illegal"},   illegal,   e_ill);
        check({tag, ".rd"},        rd,        e_rd);
    endtask

    initial begin
        logic [31:0] ill_vec [8];
        ill_vec = '{32'h020000B3, 32'h00003083, 32'h00002063, 32'h000010E7,
                    32'h00003023, 32'h40001093, 32'h40002033, 32'h00000000};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        instr_in = '0; pc_in = '0;
        #2 rst = 1'b1;
        #1;
        check("rst.in_ready",  in_ready,  0);
        check("rst.out_valid", out_valid, 0);
        check("rst.RegWrite",  RegWrite,  0);
        check("rst.pc_out",    pc_out,    0);
        check("rst.ill_count", ill_count, 0);
        @(negedge clk) rst = 1'b0;
        step();
        check("post_rst.in_ready",  in_ready,  1);
        check("post_rst.out_valid", out_valid, 0);

        // Back-to-back decode, full rate.
        send("addi", 32'h00500093, 32'h100, 1, 1, 0, 4'd0, 3'd0, 3'd0, 0, 2'd0, 3'd0, 0, 5'd1);
        send("sub",  32'h402081B3, 32'h104, 1, 0, 0, 4'd1, 3'd0, 3'd0, 0, 2'd0, 3'd0, 0, 5'd3);
        check("sub.rs1", rs1, 1);
        check("sub.rs2", rs2, 2);
        send("lw",   32'h00812283, 32'h108, 1, 1, 0, 4'd0, 3'd0, 3'd2, 0, 2'd1, 3'd0, 0, 5'd5);
        check("lw.in_ready", in_ready, 1);
        in_valid = 1'b0;
        step();
        check("drain.out_valid", out_valid, 0);
        check("drain.RegWrite",  RegWrite,  0);
        check("drain.ResultSrc", ResultSrc, 0);

        // Stall: three valid inputs, execute not ready.
        out_ready = 1'b0; in_valid = 1'b1;
        instr_in = 32'h00500093; pc_in = 32'h200;
        step();
        check("stall1.out_valid", out_valid, 1);
        check("stall1.pc_out",    pc_out,    32'h200);
        check("stall1.in_ready",  in_ready,  1);
        instr_in = 32'h402081B3; pc_in = 32'h204;
        step();
        check("stall2.in_ready", in_ready, 0);
        check("stall2.pc_out",   pc_out,   32'h200);
        instr_in = 32'h00812283; pc_in = 32'h208;
        step();
        check("stall3.in_ready", in_ready, 0);
        check("stall3.pc_out",   pc_out,   32'h200);
        check("stall3.ALUCtrl",  ALUCtrl,  0);
        check("stall3.rd",       rd,       1);
        out_ready = 1'b1;
        step();
        check("release1.pc_out",   pc_out,   32'h204);
        check("release1.ALUCtrl",  ALUCtrl,  1);
        check("release1.in_ready", in_ready, 1);
        step();
        check("release2.pc_out",    pc_out,    32'h208);
        check("release2.ResultSrc", ResultSrc, 1);
        in_valid = 1'b0;
        step();
        check("release3.out_valid", out_valid, 0);

        // Remaining formats.
        send("sw",    32'h0020A223, 32'h110, 0, 1, 0, 4'd0,  3'd1, 3'd2, 1, 2'd0, 3'd0, 0, 5'd4);
        send("bne",   32'h00209063, 32'h114, 0, 0, 0, 4'd1,  3'd2, 3'd0, 0, 2'd0, 3'd2, 0, 5'd0);
        send("bge",   32'h0020D063, 32'h118, 0, 0, 0, 4'd8,  3'd2, 3'd0, 0, 2'd0, 3'd1, 0, 5'd0);
        send("bltu",  32'h0020E063, 32'h11C, 0, 0, 0, 4'd9,  3'd2, 3'd0, 0, 2'd0, 3'd2, 0, 5'd0);
        send("lui",   32'h123452B7, 32'h120, 1, 1, 0, 4'd10, 3'd3, 3'd0, 0, 2'd0, 3'd0, 0, 5'd5);
        send("auipc", 32'h00001317, 32'h124, 1, 1, 1, 4'd0,  3'd3, 3'd0, 0, 2'd0, 3'd0, 0, 5'd6);
        send("jalr",  32'h000100E7, 32'h128, 1, 1, 0, 4'd0,  3'd0, 3'd0, 0, 2'd2, 3'd4, 0, 5'd1);
        send("srai",  32'h4030D393, 32'h12C, 1, 1, 0, 4'd7,  3'd0, 3'd0, 0, 2'd0, 3'd0, 0, 5'd7);
        send("sltu",  32'h0020B433, 32'h130, 1, 0, 0, 4'd9,  3'd0, 3'd0, 0, 2'd0, 3'd0, 0, 5'd8);
        send("lhu",   32'h0020D483, 32'h134, 1, 1, 0, 4'd0,  3'd0, 3'd5, 0, 2'd1, 3'd0, 0, 5'd9);

        // Illegal followed by JAL x0.
        send("ill0", 32'hFFFFFFFF, 32'h300, 0, 0, 0, 4'd0, 3'd0, 3'd0, 0, 2'd0, 3'd0, 1, 5'd31);
        check("ill0.ill_count",   ill_count,   1);
        check("ill0.sat_count",   s_ill_count, 1);
        send("jal",  32'h0000006F, 32'h304, 0, 1, 1, 4'd0, 3'd4, 3'd0, 0, 2'd2, 3'd3, 0, 5'd0);
        check("jal.ill_count", ill_count, 1);

        for (int i = 0; i < 8; i++) begin
            send($sformatf("ill%0d", i + 1), ill_vec[i], 32'h308 + 32'(4 * i),
                 0, 0, 0, 4'd0, 3'd0, 3'd0, 0, 2'd0, 3'd0, 1, ill_vec[i][11:7]);
            check($sformatf("ill%0d.ill_count", i + 1), ill_count, 32'(i + 2));
            check($sformatf("ill%0d.sat_count", i + 1), s_ill_count, (i + 2 > 3) ? 32'd3 : 32'(i + 2));
        end
        in_valid = 1'b0;
        step();
        check("ill_drain.out_valid", out_valid, 0);

        // Flush with the buffer full.
        out_ready = 1'b0; in_valid = 1'b1;
        instr_in = 32'h00500093; pc_in = 32'h400;
        step();
        instr_in = 32'h402081B3; pc_in = 32'h404;
        step();
        check("flush2.pre_in_ready", in_ready, 0);
        flush = 1'b1; instr_in = 32'hFFFFFFFF; pc_in = 32'h408;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush2.out_valid", out_valid, 0);
        check("flush2.in_ready",  in_ready,  1);
        check("flush2.ill_count", ill_count, 9);

        // Flush with one buffered and a concurrent accepted illegal.
        in_valid = 1'b1; instr_in = 32'h00500093; pc_in = 32'h500;
        step();
        check("flush1.pre_pc", pc_out, 32'h500);
        flush = 1'b1; instr_in = 32'hFFFFFFFF; pc_in = 32'h504;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush1.out_valid", out_valid,   0);
        check("flush1.ill_count", ill_count,   9);
        check("flush1.sat_count", s_ill_count, 3);
        check("flush1.pc_out",    pc_out,      0);
        step();
        check("flush1.stays_empty", out_valid, 0);

        // Asynchronous reset while two entries are buffered.
        in_valid = 1'b1; instr_in = 32'h00500093; pc_in = 32'h600;
        step();
        instr_in = 32'h402081B3; pc_in = 32'h604;
        step();
        check("arst.pre_in_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("arst.out_valid", out_valid,   0);
        check("arst.pc_out",    pc_out,      0);
        check("arst.RegWrite",  RegWrite,    0);
        check("arst.ALUCtrl",   ALUCtrl,     0);
        check("arst.in_ready",  in_ready,    0);
        check("arst.ill_count", ill_count,   0);
        check("arst.sat_count", s_ill_count, 0);
        in_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        step();
        check("arst.post_in_ready",  in_ready,  1);
        check("arst.post_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
